serial_addsub_ctrl: RTL

Bit-serial add/subtract sequencer. It shares a single 1-bit full-adder/full-subtractor cell across an N-bit operation, processing one bit per clock, LSB first. It takes an operand pair through a valid/ready handshake, runs N cycles, and presents an N-bit result plus carry-out/borrow-out through a valid/ready handshake. It is intended as the area-minimal arithmetic unit in small datapaths.

---
 rtl/serial_addsub_ctrl_pkg.sv | 15 +
 rtl/serial_addsub_ctrl_if.sv | 33 +++
 rtl/serial_addsub_ctrl_fa_fs_bit.sv | 23 ++
 rtl/serial_addsub_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package addsub_pkg;

  // Sequencer states: waiting for operands, shifting bits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select encoding.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Operand and result channels of the bit-serial add/subtract sequencer.
//
// Handshake: both channels use strict valid/ready. A transfer happens on a
// rising clk edge where valid and ready are both high. The producer holds its
// payload stable while valid is high and ready is low; valid never depends on
// ready. in_ready is high only when the sequencer is idle; out_valid stays high
// with result/cb_out held until out_ready is seen.
interface serial_addsub_ctrl_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         cb_out;
  logic         busy;

  // Sequencer side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cb_out, busy
  );

  // Requester / consumer side.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cb_out, busy
  );
endinterface

// File: rtl/serial_addsub_ctrl_fa_fs_bit.sv
// Combinational 1-bit full adder / full subtractor cell, time-shared by the
// sequencer across all bit positions.
module fa_fs_bit
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cbi,
  input  logic op,
  output logic r,
  output logic cbo
);

  // Sum and difference bits are identical; only the carry/borrow differs.
  always_comb begin
    r   = a ^ b ^ cbi;
    cbo = (a & b) | (cbi & (a ^ b));
    if (op == OP_SUB) begin
      cbo = (~a & b) | (~(a ^ b) & cbi);
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: accepts an operand pair, processes one
// bit per clock LSB first through a single shared full adder/subtractor cell,
// and presents the N-bit result plus final carry/borrow until consumed.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_ctrl_if.slave  bus,
  output state_t               state_dbg
);

  localparam int CW = $clog2(N);

  state_t          state;
  state_t          state_nxt;

  logic [N-1:0]    a_sr;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    res_sr;
  logic            op_r;
  logic            cb_r;
  logic [CW-1:0]   cnt;

  logic            cell_r;
  logic            cell_cbo;
  logic            accept;
  logic            last_bit;

  // An operation is taken only from IDLE; in_valid elsewhere is ignored.
  assign accept   = (state == IDLE) && bus.in_valid;
  // The edge that processes the MSB is the one leaving RUN.
  assign last_bit = (cnt == CW'(N - 1));

  // Single shared bit cell fed from the operand LSBs and the carry/borrow flop.
  fa_fs_bit u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cbi (cb_r),
    .op  (op_r),
    .r   (cell_r),
    .cbo (cell_cbo)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand load on acceptance, then one shift per RUN cycle. The result
  // register fills from the MSB end so bit 0 lands at result[0] after N shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= OP_ADD;
      cb_r   <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      op_r <= bus.op;
      cb_r <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[N-1:1]};
      b_sr   <= {1'b0, b_sr[N-1:1]};
      res_sr <= {cell_r, res_sr[N-1:1]};
      cb_r   <= cell_cbo;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result and final carry/borrow come straight from registers.
  assign bus.result = res_sr;
  assign bus.cb_out = cb_r;
  assign state_dbg  = state;

endmodule
